issue_regread_buf: RTL and testbench
====================================

Name: issue_regread_buf

Overview:
- Parametrised issue/register-read stage between the per-FU-class reservation-station selectors and the functional units.
- Each of NUM_CH channels accepts one selected instruction per cycle and drives its two physical source indices to the register file. It captures the operand values with the payload and presents an issue packet to the FU under a valid/ready handshake.
- Unlike the fixed single-register issue stage, it supports per-channel backpressure through a 2-entry skid buffer, branch-mask squash/clear while instructions are held, and optional CDB operand refresh.

Parameters:
- NUM_CH, 8: number of issue channels (ALU+MULT+LD+ST+BR concatenated, ALU at channel 0).
- PREG_IDX_W, 6: physical register index width.
- DATA_W, 32: operand width.
- BMASK_W, 4: branch-mask width (one bit per in-flight branch).
- PAYLOAD_W, 96: opaque RS packet width, passed through untouched.
- NUM_CDB, 2: CDB broadcast ports (used only with the optional feature).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  NUM_CH  selector presents an instruction.
- in_ready  out  NUM_CH  channel can accept (registered).
- in_rs1_idx, in_rs2_idx  in  NUM_CH*PREG_IDX_W  source tags.
- in_bmask  in  NUM_CH*BMASK_W  branch dependence mask.
- in_payload  in  NUM_CH*PAYLOAD_W  RS packet.
- rf_idx_1, rf_idx_2  out  NUM_CH*PREG_IDX_W  regfile read indices; combinational copy of in_rs*_idx.
- rf_data_1, rf_data_2  in  NUM_CH*DATA_W  regfile read data, valid in the same cycle.
- out_valid  out  NUM_CH  issue packet valid.
- out_ready  in  NUM_CH  FU accepts the packet.
- out_rs1_value, out_rs2_value  out  NUM_CH*DATA_W  captured operands.
- out_bmask  out  NUM_CH*BMASK_W; out_payload  out  NUM_CH*PAYLOAD_W.
- br_valid  in  1  branch resolved this cycle.
- br_id  in  BMASK_W  one-hot branch bit.
- br_mispredict  in  1  resolved branch mispredicted.
- cdb_valid  in  NUM_CDB; cdb_tag  in  NUM_CDB*PREG_IDX_W; cdb_data  in  NUM_CDB*DATA_W.

Behaviour:
- Per channel: main entry M (drives out_*) and skid entry S. Each entry holds valid, both tags, both values, bmask and payload.
- Channel state:
  - EMPTY: M and S invalid.
  - ONE: M valid, S invalid.
  - TWO: M and S valid.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !S.valid, registered. Upstream must hold its instruction while in_ready=0.
- Transitions:
  - EMPTY: in_fire -> ONE (capture into M).
  - ONE: in_fire & !out_fire -> TWO (capture into S); in_fire & out_fire -> ONE (replace M); out_fire only -> EMPTY.
  - TWO: out_fire -> ONE (S moves to M, S cleared). In TWO, in_ready=0, so no capture.
- Latency: 1 cycle from in_fire to out_valid. Full throughput when out_ready is held high.
- Capture: values come from rf_data_* in the in_fire cycle. Index 0 captures value 0 regardless of rf_data.
- Squash (br_valid & br_mispredict):
  - Every held entry with (bmask & br_id) != 0 is invalidated at the edge.
  - An incoming instruction with that bit set is not captured.
  - If M is squashed while S survives, S moves to M.
  - out_valid reflects the post-squash state on the next cycle.
- Clear (br_valid & !br_mispredict): br_id bit cleared in all held bmasks and in the incoming bmask at capture.
- Squash and clear act on the same edge as handshake events; squash takes priority over out_fire.
- Reset: all entries invalid. in_ready=1; out_valid=0; out_* data=0.
  - Assertion mid-operation discards all held instructions immediately (asynchronously).
- Payload passes through bit-exact.

Optional Feature:
- Macro ISSUE_CDB_REFRESH_EN.
- Defined:
  - Each cycle, every held operand whose tag matches a valid cdb_tag (tag != 0) is overwritten with cdb_data. The lowest CDB port wins on duplicates.
  - A match in the in_fire cycle overrides rf_data. This covers same-cycle writeback/read races.
- Undefined: cdb_* ports are ignored. Operands are only ever taken from rf_data.

Test Plan:
- Streaming: ch0 in_valid=1 for 4 cycles, tags 5/6, rf_data 0x11/0x22, out_ready=1 -> out_valid next cycle each cycle, values 0x11/0x22, in_ready stays 1.
- Backpressure: ch2 out_ready=0, two in_fire -> state TWO, in_ready=0. Raise out_ready -> packets emerge in order over 2 cycles, then in_ready=1.
- Squash: M bmask 0b0010, S bmask 0b0100, br_valid=1 br_id=0b0010 br_mispredict=1 -> M dropped, S presented next cycle with bmask 0b0100.
- Clear: held bmask 0b0110, br_id=0b0100 correct -> out_bmask 0b0010, out_valid unchanged.
- Reset: drive reset=0 mid-cycle while in TWO -> out_valid=0 and in_ready=1 without waiting for a clock edge.
- ISSUE_CDB_REFRESH_EN: held rs1 tag 9, cdb tag 9 data 0xABCD -> out_rs1_value=0xABCD next cycle. Tag 0 broadcast -> no change.

Source files
------------

// File: rtl/issue_regread_buf.sv
// Issue/register-read stage: per-channel 2-entry skid buffer with branch squash/clear.
// Optional CDB operand refresh is enabled by defining ISSUE_CDB_REFRESH_EN.
module issue_regread_buf #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned PREG_IDX_W = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BMASK_W    = 4,
  parameter int unsigned PAYLOAD_W  = 96,
  parameter int unsigned NUM_CDB    = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               in_valid,
  output logic [NUM_CH-1:0]               in_ready,
  input  logic [NUM_CH*PREG_IDX_W-1:0]    in_rs1_idx,
  input  logic [NUM_CH*PREG_IDX_W-1:0]    in_rs2_idx,
  input  logic [NUM_CH*BMASK_W-1:0]       in_bmask,
  input  logic [NUM_CH*PAYLOAD_W-1:0]     in_payload,
  output logic [NUM_CH*PREG_IDX_W-1:0]    rf_idx_1,
  output logic [NUM_CH*PREG_IDX_W-1:0]    rf_idx_2,
  input  logic [NUM_CH*DATA_W-1:0]        rf_data_1,
  input  logic [NUM_CH*DATA_W-1:0]        rf_data_2,
  output logic [NUM_CH-1:0]               out_valid,
  input  logic [NUM_CH-1:0]               out_ready,
  output logic [NUM_CH*DATA_W-1:0]        out_rs1_value,
  output logic [NUM_CH*DATA_W-1:0]        out_rs2_value,
  output logic [NUM_CH*BMASK_W-1:0]       out_bmask,
  output logic [NUM_CH*PAYLOAD_W-1:0]     out_payload,
  input  logic                            br_valid,
  input  logic [BMASK_W-1:0]              br_id,
  input  logic                            br_mispredict,
  input  logic [NUM_CDB-1:0]              cdb_valid,
  input  logic [NUM_CDB*PREG_IDX_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]       cdb_data
);

  typedef struct packed {
    logic [PREG_IDX_W-1:0] rs1_idx;
    logic [PREG_IDX_W-1:0] rs2_idx;
    logic [DATA_W-1:0]     rs1_value;
    logic [DATA_W-1:0]     rs2_value;
    logic [BMASK_W-1:0]    bmask;
    logic [PAYLOAD_W-1:0]  payload;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ch_state_e;

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  entry_t            m_q [NUM_CH];
  entry_t            m_d [NUM_CH];
  entry_t            s_q [NUM_CH];
  entry_t            s_d [NUM_CH];
  logic [NUM_CH-1:0] in_ready_q;
  logic [NUM_CH-1:0] in_ready_d;
  logic [NUM_CH-1:0] out_valid_q;
  logic [NUM_CH-1:0] out_valid_d;

  logic squash;
  logic clear;

  assign squash = br_valid & br_mispredict;
  assign clear  = br_valid & ~br_mispredict;

`ifdef ISSUE_CDB_REFRESH_EN
  // Lowest-numbered CDB port wins: scan high to low so the last hit is port 0.
  function automatic logic [DATA_W-1:0] cdb_pick(
    input logic [PREG_IDX_W-1:0]         tag,
    input logic [DATA_W-1:0]             cur,
    input logic [NUM_CDB-1:0]            cv,
    input logic [NUM_CDB*PREG_IDX_W-1:0] ct,
    input logic [NUM_CDB*DATA_W-1:0]     cd
  );
    logic [DATA_W-1:0] v;
    v = cur;
    for (int p = int'(NUM_CDB) - 1; p >= 0; p--) begin
      if (cv[p] && (tag != '0) && (ct[p*PREG_IDX_W +: PREG_IDX_W] == tag)) begin
        v = cd[p*DATA_W +: DATA_W];
      end
    end
    return v;
  endfunction
`else
  logic unused_cdb;
  assign unused_cdb = ^{1'b0, cdb_valid, cdb_tag, cdb_data};
`endif

  // Next-state: squash/clear and refresh the held entries, then repack survivors into M/S.
  always_comb begin
    entry_t m_h;
    entry_t s_h;
    entry_t inc;
    logic   m_kill;
    logic   s_kill;
    logic   m_stay;
    logic   s_stay;
    logic   cap;
    m_h    = '0;
    s_h    = '0;
    inc    = '0;
    m_kill = 1'b0;
    s_kill = 1'b0;
    m_stay = 1'b0;
    s_stay = 1'b0;
    cap    = 1'b0;
    in_ready_d  = '0;
    out_valid_d = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      state_d[c] = state_q[c];
      m_d[c]     = m_q[c];
      s_d[c]     = s_q[c];

      m_h = m_q[c];
      s_h = s_q[c];

      inc.rs1_idx   = in_rs1_idx[c*PREG_IDX_W +: PREG_IDX_W];
      inc.rs2_idx   = in_rs2_idx[c*PREG_IDX_W +: PREG_IDX_W];
      inc.rs1_value = (inc.rs1_idx == '0) ? '0 : rf_data_1[c*DATA_W +: DATA_W];
      inc.rs2_value = (inc.rs2_idx == '0) ? '0 : rf_data_2[c*DATA_W +: DATA_W];
      inc.bmask     = in_bmask[c*BMASK_W +: BMASK_W];
      inc.payload   = in_payload[c*PAYLOAD_W +: PAYLOAD_W];

      m_kill = squash & (|(m_h.bmask & br_id));
      s_kill = squash & (|(s_h.bmask & br_id));
      cap    = in_valid[c] & in_ready_q[c] & ~(squash & (|(inc.bmask & br_id)));

      if (clear) begin
        m_h.bmask = m_h.bmask & ~br_id;
        s_h.bmask = s_h.bmask & ~br_id;
        inc.bmask = inc.bmask & ~br_id;
      end

`ifdef ISSUE_CDB_REFRESH_EN
      m_h.rs1_value = cdb_pick(m_h.rs1_idx, m_h.rs1_value, cdb_valid, cdb_tag, cdb_data);
      m_h.rs2_value = cdb_pick(m_h.rs2_idx, m_h.rs2_value, cdb_valid, cdb_tag, cdb_data);
      s_h.rs1_value = cdb_pick(s_h.rs1_idx, s_h.rs1_value, cdb_valid, cdb_tag, cdb_data);
      s_h.rs2_value = cdb_pick(s_h.rs2_idx, s_h.rs2_value, cdb_valid, cdb_tag, cdb_data);
      inc.rs1_value = cdb_pick(inc.rs1_idx, inc.rs1_value, cdb_valid, cdb_tag, cdb_data);
      inc.rs2_value = cdb_pick(inc.rs2_idx, inc.rs2_value, cdb_valid, cdb_tag, cdb_data);
`endif

      // M leaves on out_fire or squash; squash dominates either way.
      m_stay = (state_q[c] != ST_EMPTY) & ~m_kill & ~out_ready[c];
      s_stay = (state_q[c] == ST_TWO) & ~s_kill;

      if (m_stay) begin
        m_d[c] = m_h;
        if (s_stay) begin
          s_d[c]     = s_h;
          state_d[c] = ST_TWO;
        end else if (cap) begin
          s_d[c]     = inc;
          state_d[c] = ST_TWO;
        end else begin
          state_d[c] = ST_ONE;
        end
      end else if (s_stay) begin
        m_d[c]     = s_h;
        state_d[c] = ST_ONE;
      end else if (cap) begin
        m_d[c]     = inc;
        state_d[c] = ST_ONE;
      end else begin
        state_d[c] = ST_EMPTY;
      end

      in_ready_d[c]  = (state_d[c] != ST_TWO);
      out_valid_d[c] = (state_d[c] != ST_EMPTY);
    end
  end

  // Channel state and handshake flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        state_q[c] <= ST_EMPTY;
      end
      in_ready_q  <= '1;
      out_valid_q <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        state_q[c] <= state_d[c];
      end
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        m_q[c] <= '0;
        s_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        m_q[c] <= m_d[c];
        s_q[c] <= s_d[c];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign rf_idx_1  = in_rs1_idx;
  assign rf_idx_2  = in_rs2_idx;

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_out
    assign out_rs1_value[g*DATA_W +: DATA_W]     = m_q[g].rs1_value;
    assign out_rs2_value[g*DATA_W +: DATA_W]     = m_q[g].rs2_value;
    assign out_bmask[g*BMASK_W +: BMASK_W]       = m_q[g].bmask;
    assign out_payload[g*PAYLOAD_W +: PAYLOAD_W] = m_q[g].payload;
`ifndef ISSUE_CDB_REFRESH_EN
    logic unused_tags;
    assign unused_tags = ^{1'b0, m_q[g].rs1_idx, m_q[g].rs2_idx, s_q[g].rs1_idx, s_q[g].rs2_idx};
`endif
  end

endmodule

// File: tb/tb_issue_regread_buf.sv
// Directed bench for issue_regread_buf: streaming, backpressure, squash, clear, async reset, CDB.
module tb_issue_regread_buf;

  localparam int unsigned NCH = 8;
  localparam int unsigned IW  = 6;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 4;
  localparam int unsigned PW  = 96;
  localparam int unsigned NC  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*IW-1:0] in_rs1_idx;
  logic [NCH*IW-1:0] in_rs2_idx;
  logic [NCH*BW-1:0] in_bmask;
  logic [NCH*PW-1:0] in_payload;
  logic [NCH*IW-1:0] rf_idx_1;
  logic [NCH*IW-1:0] rf_idx_2;
  logic [NCH*DW-1:0] rf_data_1;
  logic [NCH*DW-1:0] rf_data_2;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*DW-1:0] out_rs1_value;
  logic [NCH*DW-1:0] out_rs2_value;
  logic [NCH*BW-1:0] out_bmask;
  logic [NCH*PW-1:0] out_payload;
  logic              br_valid;
  logic [BW-1:0]     br_id;
  logic              br_mispredict;
  logic [NC-1:0]     cdb_valid;
  logic [NC*IW-1:0]  cdb_tag;
  logic [NC*DW-1:0]  cdb_data;

  int checks = 0;
  int errors = 0;

  issue_regread_buf dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1_idx    (in_rs1_idx),
    .in_rs2_idx    (in_rs2_idx),
    .in_bmask      (in_bmask),
    .in_payload    (in_payload),
    .rf_idx_1      (rf_idx_1),
    .rf_idx_2      (rf_idx_2),
    .rf_data_1     (rf_data_1),
    .rf_data_2     (rf_data_2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rs1_value (out_rs1_value),
    .out_rs2_value (out_rs2_value),
    .out_bmask     (out_bmask),
    .out_payload   (out_payload),
    .br_valid      (br_valid),
    .br_id         (br_id),
    .br_mispredict (br_mispredict),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int c, input logic v, input logic [IW-1:0] t1, input logic [IW-1:0] t2,
                       input logic [BW-1:0] bm, input logic [PW-1:0] pl,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    in_valid[c]            = v;
    in_rs1_idx[c*IW +: IW] = t1;
    in_rs2_idx[c*IW +: IW] = t2;
    in_bmask[c*BW +: BW]   = bm;
    in_payload[c*PW +: PW] = pl;
    rf_data_1[c*DW +: DW]  = d1;
    rf_data_2[c*DW +: DW]  = d2;
  endtask

  function automatic logic [127:0] o_rs1(input int c);
    return 128'(out_rs1_value[c*DW +: DW]);
  endfunction
  function automatic logic [127:0] o_rs2(input int c);
    return 128'(out_rs2_value[c*DW +: DW]);
  endfunction
  function automatic logic [127:0] o_bm(input int c);
    return 128'(out_bmask[c*BW +: BW]);
  endfunction
  function automatic logic [127:0] o_pl(input int c);
    return 128'(out_payload[c*PW +: PW]);
  endfunction

  initial begin
    logic [DW-1:0] exp_v;
    reset         = 1'b0;
    in_valid      = '0;
    in_rs1_idx    = '0;
    in_rs2_idx    = '0;
    in_bmask      = '0;
    in_payload    = '0;
    rf_data_1     = '0;
    rf_data_2     = '0;
    out_ready     = '1;
    br_valid      = 1'b0;
    br_id         = '0;
    br_mispredict = 1'b0;
    cdb_valid     = '0;
    cdb_tag       = '0;
    cdb_data      = '0;

    repeat (2) step();
    chk_eq("rst_in_ready", 128'(in_ready), 128'({NCH{1'b1}}));
    chk_eq("rst_out_valid", 128'(out_valid), 128'(0));
    chk_eq("rst_out_payload0", o_pl(0), 128'(0));
    chk_eq("rst_out_rs1_0", o_rs1(0), 128'(0));
    reset = 1'b1;

    // Streaming on channel 0.
    drive(0, 1'b1, 6'd5, 6'd6, 4'b0000, 96'd1, 32'h11, 32'h22);
    #1;
    chk_eq("rf_idx_1_copy", 128'(rf_idx_1[IW-1:0]), 128'(5));
    chk_eq("rf_idx_2_copy", 128'(rf_idx_2[IW-1:0]), 128'(6));
    for (int k = 0; k < 4; k++) begin
      step();
      chk_eq("stream_valid", 128'(out_valid[0]), 128'(1));
      chk_eq("stream_rs1", o_rs1(0), 128'(32'h11));
      chk_eq("stream_rs2", o_rs2(0), 128'(32'h22));
      chk_eq("stream_payload", o_pl(0), 128'(k + 1));
      chk_eq("stream_in_ready", 128'(in_ready[0]), 128'(1));
      if (k < 3) drive(0, 1'b1, 6'd5, 6'd6, 4'b0000, 96'(k + 2), 32'h11, 32'h22);
      else       drive(0, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
    end
    step();
    chk_eq("stream_drain", 128'(out_valid[0]), 128'(0));

    // Backpressure on channel 2; second packet also exercises rs2 index 0.
    out_ready[2] = 1'b0;
    drive(2, 1'b1, 6'd1, 6'd2, 4'b0000, 96'hA, 32'hA1, 32'hA2);
    step();
    chk_eq("bp_one_ready", 128'(in_ready[2]), 128'(1));
    drive(2, 1'b1, 6'd3, 6'd0, 4'b0000, 96'hB, 32'hB1, 32'hB2);
    step();
    drive(2, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
    chk_eq("bp_two_ready", 128'(in_ready[2]), 128'(0));
    chk_eq("bp_two_valid", 128'(out_valid[2]), 128'(1));
    chk_eq("bp_two_head", o_pl(2), 128'(96'hA));
    chk_eq("bp_head_rs1", o_rs1(2), 128'(32'hA1));
    out_ready[2] = 1'b1;
    step();
    chk_eq("bp_second_payload", o_pl(2), 128'(96'hB));
    chk_eq("bp_second_rs1", o_rs1(2), 128'(32'hB1));
    chk_eq("bp_idx0_zero", o_rs2(2), 128'(0));
    chk_eq("bp_second_ready", 128'(in_ready[2]), 128'(1));
    step();
    chk_eq("bp_empty_valid", 128'(out_valid[2]), 128'(0));
    chk_eq("bp_empty_ready", 128'(in_ready[2]), 128'(1));

    // Squash: ch3 M masked out while S survives; incoming on ch4 dropped, ch5 kept.
    out_ready[3] = 1'b0;
    out_ready[4] = 1'b0;
    out_ready[5] = 1'b0;
    drive(3, 1'b1, 6'd7, 6'd8, 4'b0010, 96'h31, 32'h31, 32'h32);
    step();
    drive(3, 1'b1, 6'd7, 6'd8, 4'b0100, 96'h32, 32'h33, 32'h34);
    step();
    drive(3, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
    chk_eq("sq_pre_ready", 128'(in_ready[3]), 128'(0));
    br_valid      = 1'b1;
    br_id         = 4'b0010;
    br_mispredict = 1'b1;
    drive(4, 1'b1, 6'd1, 6'd1, 4'b0010, 96'h4, 32'h4, 32'h4);
    drive(5, 1'b1, 6'd1, 6'd1, 4'b0001, 96'h5, 32'h5, 32'h5);
    step();
    br_valid      = 1'b0;
    br_mispredict = 1'b0;
    drive(4, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
    drive(5, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
    chk_eq("sq_s_valid", 128'(out_valid[3]), 128'(1));
    chk_eq("sq_s_payload", o_pl(3), 128'(96'h32));
    chk_eq("sq_s_bmask", o_bm(3), 128'(4'b0100));
    chk_eq("sq_ready", 128'(in_ready[3]), 128'(1));
    chk_eq("sq_in_dropped", 128'(out_valid[4]), 128'(0));
    chk_eq("sq_in_kept", 128'(out_valid[5]), 128'(1));
    chk_eq("sq_in_kept_payload", o_pl(5), 128'(96'h5));

    // Clear: held and incoming masks lose the resolved bit.
    out_ready[6] = 1'b0;
    out_ready[7] = 1'b0;
    drive(6, 1'b1, 6'd2, 6'd3, 4'b0110, 96'h6, 32'h6, 32'h6);
    step();
    drive(6, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
    br_valid      = 1'b1;
    br_id         = 4'b0100;
    br_mispredict = 1'b0;
    drive(7, 1'b1, 6'd2, 6'd3, 4'b0101, 96'h7, 32'h7, 32'h7);
    step();
    br_valid = 1'b0;
    drive(7, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
    chk_eq("clr_held_bmask", o_bm(6), 128'(4'b0010));
    chk_eq("clr_held_valid", 128'(out_valid[6]), 128'(1));
    chk_eq("clr_in_bmask", o_bm(7), 128'(4'b0001));

    // Asynchronous reset while ch2 holds two entries.
    out_ready[2] = 1'b0;
    drive(2, 1'b1, 6'd4, 6'd4, 4'b0000, 96'hC, 32'hC, 32'hC);
    step();
    drive(2, 1'b1, 6'd4, 6'd4, 4'b0000, 96'hD, 32'hD, 32'hD);
    step();
    drive(2, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
    chk_eq("ar_pre_ready", 128'(in_ready[2]), 128'(0));
    #2;
    reset = 1'b0;
    #1;
    chk_eq("ar_out_valid", 128'(out_valid), 128'(0));
    chk_eq("ar_in_ready", 128'(in_ready), 128'({NCH{1'b1}}));
    chk_eq("ar_payload", o_pl(2), 128'(0));
    step();
    reset = 1'b1;

    // CDB refresh of a held operand (ignored unless the feature is built in).
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 6'd9, 6'd0, 4'b0000, 96'h1, 32'h5, 32'h77);
    step();
    drive(1, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
    chk_eq("cdb_pre_rs1", o_rs1(1), 128'(32'h5));
    chk_eq("cdb_pre_rs2", o_rs2(1), 128'(0));
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd9};
    cdb_data  = {32'h0, 32'hABCD};
    step();
`ifdef ISSUE_CDB_REFRESH_EN
    exp_v = 32'hABCD;
`else
    exp_v = 32'h5;
`endif
    chk_eq("cdb_hit_rs1", o_rs1(1), 128'(exp_v));
    cdb_tag  = {6'd0, 6'd0};
    cdb_data = {32'h0, 32'h1234};
    step();
    chk_eq("cdb_tag0_rs2", o_rs2(1), 128'(0));
    chk_eq("cdb_tag0_rs1", o_rs1(1), 128'(exp_v));
    cdb_valid = 2'b11;
    cdb_tag   = {6'd9, 6'd9};
    cdb_data  = {32'h2222, 32'h1111};
    out_ready[0] = 1'b0;
    drive(0, 1'b1, 6'd9, 6'd3, 4'b0000, 96'h2, 32'h5, 32'h6);
    step();
    cdb_valid = '0;
    drive(0, 1'b0, 6'd0, 6'd0, 4'b0000, 96'd0, 32'h0, 32'h0);
`ifdef ISSUE_CDB_REFRESH_EN
    exp_v = 32'h1111;
`else
    exp_v = 32'h5;
`endif
    chk_eq("cdb_low_port_held", o_rs1(1), 128'(exp_v));
    chk_eq("cdb_capture_override", o_rs1(0), 128'(exp_v));
    chk_eq("cdb_capture_rs2", o_rs2(0), 128'(32'h6));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
